// File: rtl/hazard_stage_tracker_pkg.sv
// Shared widths, constants and T encodings for hazard bookkeeping.
// Imported by the tracker interface, top and decrement helper.
package hazard_stage_tracker_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int T_W_DEF    = 2;
  localparam int STAT_W_DEF = 32;

  localparam logic [T_W_DEF-1:0]    T_ZERO   = '0;
  localparam logic [REG_AW_DEF-1:0] REG_NONE = '0;

  // D-stage timing codes produced by the decoder
  typedef enum logic [T_W_DEF-1:0] {
    T_NOW  = 2'd0,
    T_ONE  = 2'd1,
    T_TWO  = 2'd2,
    T_THR  = 2'd3
  } t_code_e;

  localparam t_code_e T_USE_BR  = T_NOW;
  localparam t_code_e T_USE_ALU = T_ONE;
  localparam t_code_e T_USE_ST  = T_TWO;
  localparam t_code_e T_NEW_ALU = T_TWO;
  localparam t_code_e T_NEW_LD  = T_THR;

endpackage

// File: rtl/hazard_stage_tracker_if.sv
// D-stage hazard inputs, stall request and E/M/W hazard fields.
// Master drives D and stall; slave is the tracker.
interface hazard_stage_tracker_if
  import hazard_stage_tracker_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int T_W    = T_W_DEF,
  parameter int STAT_W = STAT_W_DEF
);

  logic              stall;
  logic              D_valid;
  logic [REG_AW-1:0] D_rs_base;
  logic [REG_AW-1:0] D_rt;
  logic [REG_AW-1:0] D_REG_write_number;
  logic [T_W-1:0]    D_T_use_rs_base;
  logic [T_W-1:0]    D_T_use_rt;
  logic [T_W-1:0]    D_T_new;

  logic              E_valid;
  logic              M_valid;
  logic              W_valid;
  logic [REG_AW-1:0] E_rs_base;
  logic [REG_AW-1:0] E_rt;
  logic [REG_AW-1:0] M_rs_base;
  logic [REG_AW-1:0] M_rt;
  logic [REG_AW-1:0] E_REG_write_number;
  logic [REG_AW-1:0] M_REG_write_number;
  logic [REG_AW-1:0] W_REG_write_number;
  logic [T_W-1:0]    E_T_use_rs_base;
  logic [T_W-1:0]    E_T_use_rt;
  logic [T_W-1:0]    M_T_use_rs_base;
  logic [T_W-1:0]    M_T_use_rt;
  logic [T_W-1:0]    E_T_new;
  logic [T_W-1:0]    M_T_new;
  logic [T_W-1:0]    W_T_new;
  logic [STAT_W-1:0] bubble_count;
  logic [STAT_W-1:0] stall_run_max;

  modport master (
    output stall, D_valid, D_rs_base, D_rt,
    output D_REG_write_number,
    output D_T_use_rs_base, D_T_use_rt, D_T_new,
    input  E_valid, M_valid, W_valid,
    input  E_rs_base, E_rt, M_rs_base, M_rt,
    input  E_REG_write_number,
    input  M_REG_write_number,
    input  W_REG_write_number,
    input  E_T_use_rs_base, E_T_use_rt,
    input  M_T_use_rs_base, M_T_use_rt,
    input  E_T_new, M_T_new, W_T_new,
    input  bubble_count, stall_run_max
  );

  modport slave (
    input  stall, D_valid, D_rs_base, D_rt,
    input  D_REG_write_number,
    input  D_T_use_rs_base, D_T_use_rt, D_T_new,
    output E_valid, M_valid, W_valid,
    output E_rs_base, E_rt, M_rs_base, M_rt,
    output E_REG_write_number,
    output M_REG_write_number,
    output W_REG_write_number,
    output E_T_use_rs_base, E_T_use_rt,
    output M_T_use_rs_base, M_T_use_rt,
    output E_T_new, M_T_new, W_T_new,
    output bubble_count, stall_run_max
  );

endinterface

// File: rtl/hazard_stage_tracker_tdec.sv
// Saturating decrement of one T field: 0 stays 0, else x-1.
// Instantiated once per T field per stage boundary.
module hazard_tdec
  import hazard_stage_tracker_pkg::*;
#(
  parameter int W = T_W_DEF
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = (x == '0) ? '0 : x - 1'b1;

endmodule

// File: rtl/hazard_stage_tracker.sv
// Hazard metadata pipeline D->E->M->W with stall bubbles into E.
// Optional stall statistics when HAZARD_STATS_EN is defined.
module hazard_stage_tracker
  import hazard_stage_tracker_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int T_W    = T_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input logic clk,
  input logic reset,
  hazard_stage_tracker_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
    logic [T_W-1:0]    tus;
    logic [T_W-1:0]    tut;
    logic [T_W-1:0]    tn;
  } stg_t;

  stg_t e_q;
  stg_t m_q;
  logic              w_v_q;
  logic [REG_AW-1:0] w_wr_q;
  logic [T_W-1:0]    w_tn_q;

  logic [T_W-1:0] d_tus_dec, d_tut_dec, d_tn_dec;
  logic [T_W-1:0] e_tus_dec, e_tut_dec, e_tn_dec;
  logic [T_W-1:0] m_tn_dec;

  hazard_tdec #(.W(T_W)) u_dec_d_tus (
    .x(bus.D_T_use_rs_base), .y(d_tus_dec));
  hazard_tdec #(.W(T_W)) u_dec_d_tut (
    .x(bus.D_T_use_rt), .y(d_tut_dec));
  hazard_tdec #(.W(T_W)) u_dec_d_tn (
    .x(bus.D_T_new), .y(d_tn_dec));
  hazard_tdec #(.W(T_W)) u_dec_e_tus (
    .x(e_q.tus), .y(e_tus_dec));
  hazard_tdec #(.W(T_W)) u_dec_e_tut (
    .x(e_q.tut), .y(e_tut_dec));
  hazard_tdec #(.W(T_W)) u_dec_e_tn (
    .x(e_q.tn), .y(e_tn_dec));
  hazard_tdec #(.W(T_W)) u_dec_m_tn (
    .x(m_q.tn), .y(m_tn_dec));

  // A bubble is all-zero, so it can never name a producer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
    end else if (bus.stall || !bus.D_valid) begin
      e_q <= '0;
    end else begin
      e_q <= '{v:   1'b1,
               rs:  bus.D_rs_base,
               rt:  bus.D_rt,
               wr:  bus.D_REG_write_number,
               tus: d_tus_dec,
               tut: d_tut_dec,
               tn:  d_tn_dec};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
    end else begin
      m_q <= '{v:   e_q.v,
               rs:  e_q.rs,
               rt:  e_q.rt,
               wr:  e_q.wr,
               tus: e_tus_dec,
               tut: e_tut_dec,
               tn:  e_tn_dec};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_v_q  <= 1'b0;
      w_wr_q <= '0;
      w_tn_q <= '0;
    end else begin
      w_v_q  <= m_q.v;
      w_wr_q <= m_q.wr;
      w_tn_q <= m_tn_dec;
    end
  end

  assign bus.E_valid            = e_q.v;
  assign bus.E_rs_base          = e_q.rs;
  assign bus.E_rt               = e_q.rt;
  assign bus.E_REG_write_number = e_q.wr;
  assign bus.E_T_use_rs_base    = e_q.tus;
  assign bus.E_T_use_rt         = e_q.tut;
  assign bus.E_T_new            = e_q.tn;

  assign bus.M_valid            = m_q.v;
  assign bus.M_rs_base          = m_q.rs;
  assign bus.M_rt               = m_q.rt;
  assign bus.M_REG_write_number = m_q.wr;
  assign bus.M_T_use_rs_base    = m_q.tus;
  assign bus.M_T_use_rt         = m_q.tut;
  assign bus.M_T_new            = m_q.tn;

  assign bus.W_valid            = w_v_q;
  assign bus.W_REG_write_number = w_wr_q;
  assign bus.W_T_new            = w_tn_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] bub_q;
  logic [STAT_W-1:0] run_q;
  logic [STAT_W-1:0] max_q;
  logic [STAT_W-1:0] run_inc;

  // Run length includes the current stall cycle
  assign run_inc = (run_q == '1) ? run_q : run_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bub_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else if (bus.stall) begin
      if (bub_q != '1) bub_q <= bub_q + 1'b1;
      run_q <= run_inc;
      if (run_inc > max_q) max_q <= run_inc;
    end else begin
      run_q <= '0;
    end
  end

  assign bus.bubble_count  = bub_q;
  assign bus.stall_run_max = max_q;
`else
  assign bus.bubble_count  = '0;
  assign bus.stall_run_max = '0;
`endif

endmodule
